// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised serial pattern detector with hold/release; define MATCH_CNT_EN for a saturating match counter
module seq_detector_param #(
    parameter int                 PAT_LEN = 7,
    parameter logic [PAT_LEN-1:0] PATTERN = 7'b0111110,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             j,
    input  logic             valid,
    input  logic             en,
    output logic             w,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_cnt
);
    localparam int FW = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

    typedef enum logic {SCAN, HOLD} state_t;

    state_t             state_q, state_d;
    logic [PAT_LEN-1:0] hist_q, hist_d, nh;
    logic [FW-1:0]      fill_q, fill_d;
    logic               pulse_q, pulse_d;

    if (PAT_LEN < 2 || PAT_LEN > 32 || CNT_W < 1) begin : g_bad_param
        $error("seq_detector_param: PAT_LEN must be 2..32 and CNT_W >= 1");
    end

    always_comb begin
        nh      = {hist_q[PAT_LEN-2:0], j};
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pulse_d = 1'b0;
        if (state_q == SCAN) begin
            if (valid) begin
                hist_d = nh;
                fill_d = (fill_q == FULL) ? fill_q : fill_q + FW'(1);
                // fill_q counts bits before this one, so PAT_LEN-1 means this bit completes a full window
                if (nh == PATTERN && fill_q >= FULL - FW'(1)) begin
                    state_d = HOLD;
                    pulse_d = 1'b1;
                end
            end
        end else if (en) begin
            state_d = SCAN;
            if (!OVERLAP) begin
                hist_d = '0;
                fill_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN;
            hist_q  <= '0;
            fill_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pulse_q <= pulse_d;
        end
    end

    assign w           = (state_q == HOLD);
    assign match_pulse = pulse_q;

`ifdef MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = (pulse_d && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: scoreboard bench over five detector configurations
module tb_seq_detector_param;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] j     = '0;
    logic [4:0] valid = '0;
    logic [4:0] en    = '0;
    logic [4:0] w, mp;
    logic [7:0] c0, c1, c2, c4;
    logic [1:0] c3;
    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {int dut; int stamp; int cnt;} ev_t;
    ev_t sb[$];

`ifdef MATCH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_detector_param u0 (
        .clk(clk), .rst_n(rst_n), .j(j[0]), .valid(valid[0]), .en(en[0]),
        .w(w[0]), .match_pulse(mp[0]), .match_cnt(c0));
    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .j(j[1]), .valid(valid[1]), .en(en[1]),
        .w(w[1]), .match_pulse(mp[1]), .match_cnt(c1));
    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .j(j[2]), .valid(valid[2]), .en(en[2]),
        .w(w[2]), .match_pulse(mp[2]), .match_cnt(c2));
    seq_detector_param #(.CNT_W(2)) u3 (
        .clk(clk), .rst_n(rst_n), .j(j[3]), .valid(valid[3]), .en(en[3]),
        .w(w[3]), .match_pulse(mp[3]), .match_cnt(c3));
    seq_detector_param #(.PAT_LEN(3), .PATTERN(3'b000)) u4 (
        .clk(clk), .rst_n(rst_n), .j(j[4]), .valid(valid[4]), .en(en[4]),
        .w(w[4]), .match_pulse(mp[4]), .match_cnt(c4));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One call = one clock edge with the given inputs on DUT i
    task automatic send(input int i, input logic jv, input logic vv, input logic ev,
                        input bit em, input int ec);
        @(negedge clk);
        j[i]     = jv;
        valid[i] = vv;
        en[i]    = ev;
        if (em) sb.push_back('{i, cyc + 1, ec});
        @(posedge clk);
    endtask

    task automatic pat(input int i, input logic [6:0] p, input int n, input bit em, input int ec);
        for (int k = n - 1; k >= 0; k--) send(i, p[k], 1'b1, 1'b0, em && k == 0, ec);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (mp[i]) begin
                ev_t e;
                if (sb.size() == 0) check($sformatf("unexpected_pulse_dut%0d", i), sb.size(), 1);
                else begin
                    e = sb.pop_front();
                    check("pulse_dut", i, e.dut);
                    check($sformatf("pulse_cycle_dut%0d", i), cyc, e.stamp);
                    check($sformatf("w_at_pulse_dut%0d", i), int'(w[i]), 1);
                    if (i == 3) check("match_cnt", int'(c3), e.cnt);
                end
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            j     = 5'($urandom);
            valid = 5'($urandom);
            en    = 5'($urandom);
            #1;
            check("rst_w", int'(w), 0);
            check("rst_pulse", int'(mp), 0);
            check("rst_cnt", int'(c0) + int'(c1) + int'(c2) + int'(c3) + int'(c4), 0);
        end
        @(negedge clk);
        j = '0; valid = '0; en = '0; rst_n = 1'b1;
        repeat (3) send(0, 0, 0, 0, 0, 0);
        #1;
        check("post_rst_w", int'(w), 0);
        check("post_rst_pulse", int'(mp), 0);

        // DUT0: basic detect, hold, frozen history, release
        pat(0, 7'b0111110, 7, 1, 0);
        #1;
        check("t1_w", int'(w[0]), 1);
        check("t1_pulse", int'(mp[0]), 1);
        send(0, 0, 0, 0, 0, 0);
        #1;
        check("t1_pulse_drop", int'(mp[0]), 0);
        check("t1_hold", int'(w[0]), 1);
        repeat (4) begin
            send(0, 0, 0, 0, 0, 0);
            #1 check("t1_hold_idle", int'(w[0]), 1);
        end
        repeat (3) send(0, 1, 1, 0, 0, 0);
        #1 check("t1_hold_bits", int'(w[0]), 1);
        send(0, 1, 1, 1, 0, 0);
        #1 check("t1_release", int'(w[0]), 0);
        // overlap: history 0111110 kept, six more bits complete it again
        pat(0, 7'b0111110, 6, 1, 0);
        #1 check("t2_overlap_w", int'(w[0]), 1);
        send(0, 0, 0, 1, 0, 0);
        #1 check("t2_release", int'(w[0]), 0);

        // DUT0: valid gaps with toggling invalid data
        for (int k = 6; k >= 0; k--) begin
            send(0, ~7'b0111110 >> k, 1'b0, 1'b0, 0, 0);
            if (k == 0) #1 check("t3_before_last", int'(w[0]), 0);
            send(0, 1'((7'b0111110 >> k) & 7'd1), 1'b1, 1'b0, k == 0, 0);
        end
        #1 check("t3_gap_w", int'(w[0]), 1);
        send(0, 0, 0, 1, 0, 0);

        // DUT0: asynchronous reset while holding
        pat(0, 7'b0111110, 6, 1, 0);
        send(0, 0, 0, 0, 0, 0);
        #1 check("t4_pre_rst_w", int'(w[0]), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t4_async_w", int'(w[0]), 0);
        check("t4_async_pulse", int'(mp[0]), 0);
        @(negedge clk) rst_n = 1'b1;
        pat(0, 7'b0111110, 6, 0, 0);
        #1 check("t4_fill_guard", int'(w[0]), 0);
        send(0, 0, 0, 0, 0, 0);

        // DUT1: PAT_LEN=4 with overlap
        pat(1, 7'b0001010, 4, 1, 0);
        #1 check("t5_w", int'(w[1]), 1);
        send(1, 0, 0, 1, 0, 0);
        #1 check("t5_release", int'(w[1]), 0);
        pat(1, 7'b0000010, 2, 1, 0);
        #1 check("t5_overlap_w", int'(w[1]), 1);
        send(1, 0, 0, 1, 0, 0);
        send(1, 0, 0, 0, 0, 0);

        // DUT2: no overlap; completing bit arrives with en=1
        send(2, 1, 1, 0, 0, 0);
        send(2, 0, 1, 0, 0, 0);
        send(2, 1, 1, 0, 0, 0);
        send(2, 0, 1, 1, 1, 0);
        #1 check("t6_en_in_scan", int'(w[2]), 1);
        send(2, 0, 0, 1, 0, 0);
        #1 check("t6_release", int'(w[2]), 0);
        pat(2, 7'b0000010, 2, 0, 0);
        #1 check("t6_no_overlap", int'(w[2]), 0);
        pat(2, 7'b0000010, 2, 1, 0);
        #1 check("t6_refill_w", int'(w[2]), 1);
        send(2, 0, 0, 1, 0, 0);
        send(2, 0, 0, 0, 0, 0);

        // DUT4: all-zero pattern needs a full window
        send(4, 0, 1, 0, 0, 0);
        send(4, 0, 1, 0, 0, 0);
        #1 check("t7_zero_guard", int'(w[4]), 0);
        send(4, 0, 1, 0, 1, 0);
        #1 check("t7_zero_w", int'(w[4]), 1);
        send(4, 0, 0, 1, 0, 0);
        send(4, 0, 0, 0, 0, 0);

        // DUT3: saturating counter over five matches
        for (int m = 1; m <= 5; m++) begin
            pat(3, 7'b0111110, 7, 1, CNT_ON ? (m < 3 ? m : 3) : 0);
            send(3, 0, 0, 1, 0, 0);
            #1 check("t8_release", int'(w[3]), 0);
        end
        send(3, 0, 0, 0, 0, 0);
        #1 check("t8_final_cnt", int'(c3), CNT_ON ? 3 : 0);

        repeat (3) send(0, 0, 0, 0, 0, 0);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
